sync_fifo_lvl: RTL and testbench

Single-clock, parametrised FIFO buffer with fill-level reporting, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is the single-domain successor to the team's dual-clock FIFO. It is used wherever producer and consumer share one clock and need watermark-based flow control rather than bare full/empty.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 38 +++
 rtl/sync_fifo_lvl.sv | 108 ++++++++++
 tb/tb_sync_fifo_lvl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Defaults match the standard configuration; range limits guard the watermarks.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_LEVEL   = 6;
  localparam int DEF_AE_LEVEL   = 1;

  localparam int AF_LEVEL_MIN = 1;
  localparam int AE_LEVEL_MIN = 0;

  // Level must represent 0..DEPTH inclusive, hence one bit more than the address.
  function automatic int lvl_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int af_level_max(input int addr_width);
    return 2 ** addr_width;
  endfunction

  function automatic int ae_level_max(input int addr_width);
    return (2 ** addr_width) - 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Storage is never reset; only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value whenever no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, registered watermark flags,
// sticky overflow/underflow and synchronous flush.
module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              wr_en,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              rd_en,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [lvl_width(ADDR_WIDTH)-1:0]  level,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = lvl_width(ADDR_WIDTH);

  if (AF_LEVEL < AF_LEVEL_MIN || AF_LEVEL > af_level_max(ADDR_WIDTH)) begin : g_af_range
    $error("sync_fifo_lvl: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < AE_LEVEL_MIN || AE_LEVEL > ae_level_max(ADDR_WIDTH)) begin : g_ae_range
    $error("sync_fifo_lvl: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [LW-1:0]         level_nxt;

  // Flush blocks both accesses; a write at full rides on a same-cycle read.
  assign rd_acc    = rd_en & ~empty & ~flush;
  assign wr_acc    = wr_en & (~full | rd_acc) & ~flush;
  assign level_nxt = level + LW'(wr_acc) - LW'(rd_acc);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      level        <= level_nxt;
      rd_valid     <= rd_acc;
      full         <= (level_nxt == LW'(DEPTH));
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= LW'(AF_LEVEL));
      almost_empty <= (level_nxt <= LW'(AE_LEVEL));
      if (wr_en & ~wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en & ~rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Scoreboard bench for sync_fifo_lvl: reference queue model plus
// scenario tasks with explicit boundary expectations.
module tb_sync_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] level;
  logic       overflow;
  logic       underflow;

  sync_fifo_lvl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .AF_LEVEL   (6),
    .AE_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_ovf;
  bit         m_unf;
  bit         exp_valid;
  logic [7:0] last_rd;

  // Drives one cycle from just after a falling edge, updates the model and
  // pushes expected read data; on the next falling edge pops and compares.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f);
    bit         mrd;
    bit         mwr;
    int         sz;
    logic [5:0] exp_flags;
    logic [7:0] exp_data;
    sz      = mq.size();
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    mrd = r && (sz != 0) && !f;
    mwr = w && ((sz < 8) || mrd) && !f;
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (mrd) exp_q.push_back(mq.pop_front());
      if (mwr) mq.push_back(d);
      if (w && !mwr) m_ovf = 1'b1;
      if (r && !mrd) m_unf = 1'b1;
    end
    exp_valid = mrd;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    n_checks++;
    if (rd_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, exp_valid, $time);
    end
    n_checks++;
    if (exp_valid) begin
      exp_data = exp_q.pop_front();
      if (rd_data !== exp_data) begin
        n_fail++;
        $display("FAIL rd_data: got %h expected %h at %0t", rd_data, exp_data, $time);
      end
      last_rd = exp_data;
    end else if (rd_data !== last_rd) begin
      n_fail++;
      $display("FAIL rd_data_hold: got %h expected %h at %0t", rd_data, last_rd, $time);
    end
    n_checks++;
    if (level !== 4'(mq.size())) begin
      n_fail++;
      $display("FAIL level: got %0d expected %0d at %0t", level, mq.size(), $time);
    end
    exp_flags = {mq.size() == 8, mq.size() == 0, mq.size() >= 6, mq.size() <= 1, m_ovf, m_unf};
    n_checks++;
    if ({full, empty, almost_full, almost_empty, overflow, underflow} !== exp_flags) begin
      n_fail++;
      $display("FAIL flags(f,e,af,ae,ov,un): got %b expected %b at %0t",
               {full, empty, almost_full, almost_empty, overflow, underflow}, exp_flags, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    last_rd = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b1, 8'h3D, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Assert reset between edges and check outputs before any clock edge.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({level, empty, almost_empty, full, almost_full, rd_valid, overflow, underflow} !== {4'd0, 7'b1100000}) begin
      n_fail++;
      $display("FAIL async_reset_state: got lvl=%0d e=%b ae=%b f=%b af=%b v=%b ov=%b un=%b",
               level, empty, almost_empty, full, almost_full, rd_valid, overflow, underflow);
    end
    n_checks++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_rd_data: got %h expected 00", rd_data);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_fill_overflow_drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 1 || i == 2) begin
        n_checks++;
        if (almost_empty !== (i == 1)) begin
          n_fail++;
          $display("FAIL almost_empty_after_write%0d: got %b", i, almost_empty);
        end
      end
      if (i == 5 || i == 6) begin
        n_checks++;
        if (almost_full !== (i == 6)) begin
          n_fail++;
          $display("FAIL almost_full_after_write%0d: got %b", i, almost_full);
        end
      end
    end
    n_checks++;
    if (full !== 1'b1 || level !== 4'd8) begin
      n_fail++;
      $display("FAIL full_after_8: got full=%b level=%0d expected 1/8", full, level);
    end
    cycle(1'b1, 8'h09, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || level !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow_9th: got ov=%b level=%0d expected 1/8", overflow, level);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_read%0d: got v=%b data=%h expected 1/%h", i, rd_valid, rd_data, 8'(i));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_after_drain: got empty=%b level=%0d", empty, level);
    end
  endtask

  task automatic test_simul_full();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    n_checks++;
    if (level !== 4'd8 || rd_data !== 8'h01 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_at_full: got level=%0d data=%h ov=%b expected 8/01/0", level, rd_data, overflow);
    end
    for (int i = 1; i <= 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL simul_full_last: got %h expected aa", rd_data);
    end
  endtask

  task automatic test_empty_boundary();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_at_empty: got un=%b v=%b expected 1/0", underflow, rd_valid);
    end
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    n_checks++;
    if (level !== 4'd1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_passthrough: got level=%0d v=%b expected 1/0", level, rd_valid);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_data !== 8'h55 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_after_empty_write: got %h v=%b expected 55/1", rd_data, rd_valid);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      n_checks++;
      if (level !== 4'd3) begin
        n_fail++;
        $display("FAIL wrap_level cycle%0d: got %0d expected 3", i, level);
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_data !== 8'h23) begin
      n_fail++;
      $display("FAIL wrap_last: got %h expected 23", rd_data);
    end
  endtask

  task automatic test_flush();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (level !== 4'd5 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: got level=%0d ov=%b expected 5/1", level, overflow);
    end
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    n_checks++;
    if (level !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h32) begin
      n_fail++;
      $display("FAIL flush_result: got level=%0d e=%b ov=%b v=%b data=%h expected 0/1/0/0/32",
               level, empty, overflow, rd_valid, rd_data);
    end
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_data !== 8'h41) begin
      n_fail++;
      $display("FAIL after_flush_read: got %h expected 41", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow_drain();
    test_simul_full();
    test_empty_boundary();
    test_wrap();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
